// File: rtl/cipher_pkg.sv
// -----------------------------------------------------------------------------
// cipher_pkg
//   Shared constants and types for the cipher datapath.
//   DATA_LENGTH   : cipher block / tag width in bits
//   LENGTH        : width of the block-count (data_len) field
//   WORD_LENGTH   : width of the I/O controller bus word
//   WORDS_PER_BLK : bus words per cipher block
//   ser_state_t   : state encoding of the output serializer
// -----------------------------------------------------------------------------
package cipher_pkg;

   localparam int DATA_LENGTH   = 128;
   localparam int LENGTH        = 8;
   localparam int WORD_LENGTH   = 32;
   localparam int WORDS_PER_BLK = DATA_LENGTH / WORD_LENGTH;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CT_LOAD   = 3'd1,
      CT_SHIFT  = 3'd2,
      TAG_WAIT  = 3'd3,
      TAG_SHIFT = 3'd4,
      DONE      = 3'd5
   } ser_state_t;

endpackage

// File: rtl/cipher_word_shifter.sv
// -----------------------------------------------------------------------------
// cipher_word_shifter
//   Block-wide load / shift-left register with a word index counter. The most
//   significant word of the register is always presented on 'word'; each
//   shift moves the next word up. Shared by the ciphertext and tag phases.
//
//   clk_i     in   rising-edge clock
//   rst_i     in   asynchronous active-high reset (register and index cleared)
//   load      in   capture 'data' and restart the word index
//   data      in   BLK_W block to load
//   shift     in   advance to the next word (ignored while load is high)
//   word      out  current (most significant) word
//   last_word out  the current word is the final word of the block
// -----------------------------------------------------------------------------
module cipher_word_shifter
   import cipher_pkg::*;
#(
   parameter int BLK_W  = DATA_LENGTH,
   parameter int WORD_W = WORD_LENGTH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load,
   input  logic [BLK_W-1:0]  data,
   input  logic              shift,
   output logic [WORD_W-1:0] word,
   output logic              last_word
);

   localparam int WORDS = BLK_W / WORD_W;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   if ((BLK_W % WORD_W) != 0) begin : g_bad_width
      $error("cipher_word_shifter: BLK_W must be a multiple of WORD_W");
   end

   logic [BLK_W-1:0] shreg;
   logic [IDX_W-1:0] idx;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shreg <= '0;
         idx   <= '0;
      end else if (load) begin
         shreg <= data;
         idx   <= '0;
      end else if (shift) begin
         shreg <= shreg << WORD_W;
         idx   <= idx + 1'b1;
      end
   end

   assign word      = shreg[BLK_W-1 -: WORD_W];
   assign last_word = (idx == IDX_W'(WORDS - 1));

endmodule

// File: rtl/cipher_out_serializer.sv
// -----------------------------------------------------------------------------
// cipher_out_serializer
//   Egress stage behind cipher_core. Accepts data_len ciphertext blocks over a
//   valid/ready handshake plus the tag delivered with the finish pulse, and
//   streams them as WORD_W-bit words, most-significant word first: all
//   ciphertext words, then the tag words.
//
//   clk_i          in   rising-edge clock
//   rst_i          in   asynchronous active-high reset (silent abort)
//   start_i        in   run start pulse; latches data_len_i
//   data_len_i     in   number of ciphertext blocks in this run
//   blk_i          in   ciphertext block
//   blk_valid_i    in   ciphertext block valid
//   blk_ready_o    out  serializer can take a block (decoded from state only)
//   tag_i          in   tag, valid while finish_i is high
//   finish_i       in   core finish pulse
//   word_o         out  output word
//   word_valid_o   out  output word valid
//   word_ready_i   in   sink ready
//   word_is_tag_o  out  current word is a tag word
//   word_last_o    out  current word is the final tag word
//   busy_o         out  run in progress
//   done_o         out  one-cycle pulse after the final tag word handshake
// -----------------------------------------------------------------------------
module cipher_out_serializer
   import cipher_pkg::*;
#(
   parameter int BLK_W  = DATA_LENGTH,
   parameter int WORD_W = WORD_LENGTH,
   parameter int CNT_W  = LENGTH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  data_len_i,
   input  logic [BLK_W-1:0]  blk_i,
   input  logic              blk_valid_i,
   output logic              blk_ready_o,
   input  logic [BLK_W-1:0]  tag_i,
   input  logic              finish_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o,
   input  logic              word_ready_i,
   output logic              word_is_tag_o,
   output logic              word_last_o,
   output logic              busy_o,
   output logic              done_o
);

   ser_state_t       state, state_nxt;
   logic [CNT_W-1:0] blk_rem, blk_rem_nxt;
   logic             tag_pending, tag_pending_nxt;
   logic [BLK_W-1:0] tag_reg, tag_reg_nxt;

   logic              sh_load;
   logic              sh_shift;
   logic [BLK_W-1:0]  sh_data;
   logic [WORD_W-1:0] sh_word;
   logic              sh_last;

   cipher_word_shifter #(
      .BLK_W  (BLK_W),
      .WORD_W (WORD_W)
   ) u_shifter (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load      (sh_load),
      .data      (sh_data),
      .shift     (sh_shift),
      .word      (sh_word),
      .last_word (sh_last)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         blk_rem     <= '0;
         tag_pending <= 1'b0;
         tag_reg     <= '0;
      end else begin
         state       <= state_nxt;
         blk_rem     <= blk_rem_nxt;
         tag_pending <= tag_pending_nxt;
         tag_reg     <= tag_reg_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      blk_rem_nxt     = blk_rem;
      tag_pending_nxt = tag_pending;
      tag_reg_nxt     = tag_reg;
      sh_load         = 1'b0;
      sh_shift        = 1'b0;
      sh_data         = blk_i;
      blk_ready_o     = 1'b0;
      word_valid_o    = 1'b0;
      word_is_tag_o   = 1'b0;
      word_last_o     = 1'b0;
      busy_o          = 1'b0;
      done_o          = 1'b0;
      word_o          = sh_word;

      // The core may finish while ciphertext is still draining; keep only the
      // first tag of the run so a stray second pulse cannot corrupt it.
      if ((state != IDLE) && finish_i && !tag_pending) begin
         tag_pending_nxt = 1'b1;
         tag_reg_nxt     = tag_i;
      end

      unique case (state)
         IDLE: begin
            if (start_i) begin
               blk_rem_nxt     = data_len_i;
               tag_pending_nxt = 1'b0;
               state_nxt       = (data_len_i != '0) ? CT_LOAD : TAG_WAIT;
            end
         end

         CT_LOAD: begin
            busy_o      = 1'b1;
            blk_ready_o = 1'b1;
            if (blk_valid_i) begin
               sh_load     = 1'b1;
               sh_data     = blk_i;
               blk_rem_nxt = blk_rem - 1'b1;
               state_nxt   = CT_SHIFT;
            end
         end

         CT_SHIFT: begin
            busy_o       = 1'b1;
            word_valid_o = 1'b1;
            if (word_ready_i) begin
               sh_shift = 1'b1;
               if (sh_last) begin
                  state_nxt = (blk_rem != '0) ? CT_LOAD : TAG_WAIT;
               end
            end
         end

         TAG_WAIT: begin
            busy_o = 1'b1;
            // A tag arriving this very cycle is forwarded straight into the
            // shifter rather than waiting a cycle for tag_reg.
            if (tag_pending) begin
               sh_load   = 1'b1;
               sh_data   = tag_reg;
               state_nxt = TAG_SHIFT;
            end else if (finish_i) begin
               sh_load   = 1'b1;
               sh_data   = tag_i;
               state_nxt = TAG_SHIFT;
            end
         end

         TAG_SHIFT: begin
            busy_o        = 1'b1;
            word_valid_o  = 1'b1;
            word_is_tag_o = 1'b1;
            word_last_o   = sh_last;
            if (word_ready_i) begin
               sh_shift = 1'b1;
               if (sh_last) begin
                  state_nxt = DONE;
               end
            end
         end

         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cipher_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_cipher_out_serializer
//   Randomized scoreboard bench. Each run pushes its expected word stream
//   (ciphertext words MSW first, then tag words) into a queue; a monitor pops
//   and compares on every output handshake and checks stall stability.
// -----------------------------------------------------------------------------
module tb_cipher_out_serializer;
   import cipher_pkg::*;

   localparam int BLK_W  = DATA_LENGTH;
   localparam int WORD_W = WORD_LENGTH;
   localparam int CNT_W  = LENGTH;
   localparam int WORDS  = BLK_W / WORD_W;

   logic              clk = 1'b0;
   logic              rst_i = 1'b1;
   logic              start_i = 1'b0;
   logic [CNT_W-1:0]  data_len_i = '0;
   logic [BLK_W-1:0]  blk_i = '0;
   logic              blk_valid_i = 1'b0;
   logic              blk_ready_o;
   logic [BLK_W-1:0]  tag_i = '0;
   logic              finish_i = 1'b0;
   logic [WORD_W-1:0] word_o;
   logic              word_valid_o;
   logic              word_ready_i = 1'b1;
   logic              word_is_tag_o;
   logic              word_last_o;
   logic              busy_o;
   logic              done_o;

   cipher_out_serializer #(
      .BLK_W  (BLK_W),
      .WORD_W (WORD_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .data_len_i    (data_len_i),
      .blk_i         (blk_i),
      .blk_valid_i   (blk_valid_i),
      .blk_ready_o   (blk_ready_o),
      .tag_i         (tag_i),
      .finish_i      (finish_i),
      .word_o        (word_o),
      .word_valid_o  (word_valid_o),
      .word_ready_i  (word_ready_i),
      .word_is_tag_o (word_is_tag_o),
      .word_last_o   (word_last_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int hs_cnt  = 0;
   int ready_mode = 0;
   bit blk_ready_seen = 1'b0;

   logic [WORD_W+1:0] exp_q[$];
   logic [BLK_W-1:0]  blk_arr[8];

   task automatic chk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, req);
   endtask

   task automatic fail_now(input string nm);
      n_total++;
      $display("FAIL %s: got timeout want event", nm);
   endtask

   // Reference: ciphertext words of each block MSW first, then the tag words,
   // word_last only on the very last tag word.
   task automatic push_run(input int nblk, input logic [BLK_W-1:0] tag);
      for (int b = 0; b < nblk; b++)
         for (int w = 0; w < WORDS; w++)
            exp_q.push_back({1'b0, 1'b0, WORD_W'(blk_arr[b] >> (WORD_W * (WORDS - 1 - w)))});
      for (int w = 0; w < WORDS; w++)
         exp_q.push_back({1'b1, (w == WORDS - 1), WORD_W'(tag >> (WORD_W * (WORDS - 1 - w)))});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int len);
      data_len_i = CNT_W'(len);
      start_i    = 1'b1;
      step();
      start_i    = 1'b0;
      data_len_i = CNT_W'($urandom);
   endtask

   task automatic send_block(input logic [BLK_W-1:0] b);
      int n = 0;
      blk_i       = b;
      blk_valid_i = 1'b1;
      forever begin
         @(negedge clk);
         if (blk_ready_o) break;
         n++;
         if (n > 500) begin
            fail_now("blk_accept");
            break;
         end
      end
      step();
      blk_valid_i = 1'b0;
      blk_i       = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic pulse_finish(input logic [BLK_W-1:0] t);
      tag_i    = t;
      finish_i = 1'b1;
      step();
      finish_i = 1'b0;
      tag_i    = '0;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      forever begin
         @(negedge clk);
         if (done_o) break;
         n++;
         if (n > 3000) begin
            fail_now({nm, "_done"});
            break;
         end
      end
      chk({nm, "_done_pulse"}, done_o, 1);
      chk({nm, "_queue_empty"}, exp_q.size(), 0);
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, done_o, 0);
      chk({nm, "_busy_low"}, busy_o, 0);
      step();
   endtask

   // sink ready pattern: 0 = always, 1 = one cycle in three, 2 = random
   initial begin
      int ph = 0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: word_ready_i = 1'b1;
            1: begin
               word_ready_i = (ph == 2);
               ph = (ph + 1) % 3;
            end
            default: word_ready_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // monitor / scoreboard
   initial begin
      logic [WORD_W+2:0] held;
      bit stalled = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            stalled = 1'b0;
         end else begin
            if (blk_ready_o) blk_ready_seen = 1'b1;
            if (stalled)
               chk("stall_hold", {word_valid_o, word_is_tag_o, word_last_o, word_o}, held);
            if (word_valid_o)
               chk("blk_ready_while_shift", blk_ready_o, 0);
            if (word_valid_o && word_ready_i) begin
               hs_cnt++;
               if (exp_q.size() == 0) begin
                  n_total++;
                  $display("FAIL extra_word: got %h want none", word_o);
               end else begin
                  chk($sformatf("word%0d", hs_cnt), {word_is_tag_o, word_last_o, word_o},
                      exp_q.pop_front());
               end
               stalled = 1'b0;
            end else if (word_valid_o) begin
               stalled = 1'b1;
               held    = {1'b1, word_is_tag_o, word_last_o, word_o};
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BLK_W-1:0] tag_a5, tag_z, tag_t, tag_r;
      int base, n, len;
      tag_a5 = {16{8'ha5}};
      tag_z  = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
      tag_t  = 128'hfeed_face_1357_9bdf_2468_ace0_0f1e_2d3c;

      // reset state
      repeat (3) step();
      chk("reset_outputs", {word_o, word_valid_o, word_is_tag_o, word_last_o,
                            blk_ready_o, busy_o, done_o}, 0);
      rst_i = 1'b0;
      step();

      blk_arr[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
      blk_arr[1] = 128'hdeadbeef_cafebabe_01020304_05060708;

      // normal run, then the same run under backpressure
      for (int pass = 0; pass < 2; pass++) begin
         ready_mode = pass;
         push_run(2, tag_a5);
         do_start(2);
         chk("busy_after_start", busy_o, 1);
         send_block(blk_arr[0]);
         send_block(blk_arr[1]);
         pulse_finish(tag_a5);
         wait_done(pass == 0 ? "normal" : "backpressure");
      end

      // zero length
      ready_mode = 0;
      blk_ready_seen = 1'b0;
      push_run(0, tag_z);
      do_start(0);
      repeat (5) step();
      pulse_finish(tag_z);
      wait_done("zero_len");
      chk("zero_len_no_blk_ready", blk_ready_seen, 0);

      // early finish with tag changing afterwards, and a second finish pulse
      ready_mode = 1;
      push_run(2, tag_t);
      do_start(2);
      send_block(blk_arr[0]);
      pulse_finish(tag_t);
      send_block(blk_arr[1]);
      pulse_finish({BLK_W{1'b1}});
      wait_done("early_finish");

      // asynchronous reset while the third word of a block is presented
      ready_mode = 0;
      push_run(1, tag_a5);
      base = hs_cnt;
      do_start(1);
      send_block(blk_arr[0]);
      n = 0;
      while (hs_cnt < base + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) fail_now("reset_word2");
      @(posedge clk);
      #3;
      rst_i = 1'b1;
      #1;
      chk("reset_async_outputs", {word_o, word_valid_o, word_is_tag_o, word_last_o,
                                  blk_ready_o, busy_o, done_o}, 0);
      exp_q.delete();
      step();
      step();
      rst_i = 1'b0;
      step();
      ready_mode = 2;
      blk_arr[0] = 128'h10203040_50607080_90a0b0c0_d0e0f000;
      push_run(1, tag_t);
      do_start(1);
      send_block(blk_arr[0]);
      pulse_finish(tag_t);
      wait_done("after_reset");

      // ignored events: block valid and finish in IDLE, start while busy
      ready_mode = 0;
      blk_valid_i = 1'b1;
      finish_i    = 1'b1;
      blk_i       = {$urandom, $urandom, $urandom, $urandom};
      tag_i       = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_ignore", {blk_ready_o, word_valid_o, busy_o}, 0);
         step();
      end
      blk_valid_i = 1'b0;
      finish_i    = 1'b0;
      tag_i       = '0;
      blk_arr[0]  = 128'hcafef00d_0badc0de_11111111_22222222;
      push_run(1, tag_a5);
      do_start(1);
      data_len_i = CNT_W'(5);
      start_i    = 1'b1;
      step();
      start_i    = 1'b0;
      send_block(blk_arr[0]);
      pulse_finish(tag_a5);
      wait_done("start_while_busy");
      repeat (8) step();

      // randomized runs
      for (int r = 0; r < 8; r++) begin
         ready_mode = 2;
         len = $urandom_range(0, 3);
         for (int b = 0; b < len; b++)
            blk_arr[b] = {$urandom, $urandom, $urandom, $urandom};
         tag_r = {$urandom, $urandom, $urandom, $urandom};
         push_run(len, tag_r);
         do_start(len);
         for (int b = 0; b < len; b++)
            send_block(blk_arr[b]);
         repeat ($urandom_range(0, 5)) step();
         pulse_finish(tag_r);
         wait_done($sformatf("random%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cipher_out_serializer.md
Name: cipher_out_serializer

Overview:
Downstream stage of cipher_core. It consumes 128-bit ciphertext blocks over the outdata valid/ready handshake and the tag on finish. It emits everything as a 32-bit word stream toward the I/O controller bus: ciphertext words first, then tag words, most-significant word first. It provides the PT/CT/TAG egress path the core bench and top level need.

Parameters:
BLK_W, DATA_LENGTH (128), block width; equals the cipher_core outdata/tag width.
WORD_W, WORD_LENGTH (32), output word width; BLK_W must be an integer multiple of WORD_W.
CNT_W, LENGTH, width of the block-count input; equals cipher_core data_len width.

Ports:
clk_i  in  1  rising-edge clock
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle pulse, same cycle as cipher_core start; latches data_len_i
data_len_i  in  CNT_W  number of CT blocks to expect
blk_i  in  BLK_W  CT block (cipher_core outdata_o)
blk_valid_i  in  1  core valid
blk_ready_o  out  1  serializer ready (to core outdata_ready_i)
tag_i  in  BLK_W  tag (cipher_core tag_o)
finish_i  in  1  core finish pulse; tag_i valid in this cycle
word_o  out  WORD_W  output word
word_valid_o  out  1  output valid
word_ready_i  in  1  sink ready
word_is_tag_o  out  1  current word belongs to the tag
word_last_o  out  1  final tag word
busy_o  out  1  high from start acceptance until done
done_o  out  1  one-cycle pulse after the last tag word handshake

Behaviour:
- Reset, asynchronous, active-high:
  - state IDLE.
  - All outputs 0.
  - Shift register, tag register, counters and tag_pending cleared.
  - Reset mid-operation aborts silently; no partial words follow.
- WORDS = BLK_W/WORD_W (4). Word index counter width is clog2(WORDS). Block counter width is CNT_W.
- States: IDLE, CT_LOAD, CT_SHIFT, TAG_WAIT, TAG_SHIFT, DONE.
- IDLE:
  - busy_o=0.
  - On start_i: blk_rem <= data_len_i, tag_pending <= 0, busy_o=1 from the next cycle.
  - Next state is CT_LOAD if data_len_i != 0, else TAG_WAIT.
  - blk_valid_i and finish_i are ignored in IDLE.
- CT_LOAD:
  - blk_ready_o=1 (registered decode of state, no combinational path from word_ready_i).
  - On blk_valid_i && blk_ready_o: shreg <= blk_i, idx <= 0, blk_rem <= blk_rem-1, go to CT_SHIFT.
- CT_SHIFT:
  - word_valid_o=1, word_o = shreg[BLK_W-1 -: WORD_W], word_is_tag_o=0.
  - On a word_valid_o && word_ready_i handshake: shreg <<= WORD_W, idx++.
  - On the handshake with idx==WORDS-1: next state is CT_LOAD if blk_rem != 0, else TAG_WAIT.
  - Throughput is WORDS+1 cycles per block (one load bubble); this is accepted.
- Tag capture, in any non-IDLE state:
  - finish_i sets tag_pending and captures tag_reg <= tag_i.
  - A second finish_i before DONE is ignored.
- TAG_WAIT:
  - When tag_pending, or finish_i in this cycle (tag_i is used directly): shreg <= tag, idx <= 0, go to TAG_SHIFT.
- TAG_SHIFT:
  - Same as CT_SHIFT, with word_is_tag_o=1.
  - word_last_o=1 when idx==WORDS-1.
  - Last handshake goes to DONE.
- DONE:
  - done_o=1 for one cycle, busy_o=0.
  - Next state IDLE.
- Output stability:
  - While word_valid_o && !word_ready_i, word_o, word_is_tag_o and word_last_o hold.
  - word_valid_o does not drop until the handshake.
- Latency: a block handshake at edge N puts its first word valid in the cycle after N.
- start_i while busy_o=1 is ignored.
- data_len_i and tag_i are sampled only at their qualifying events.

Decomposition:
- cipher_pkg gains:
  - WORD_LENGTH=32.
  - WORDS_PER_BLK=DATA_LENGTH/WORD_LENGTH.
  - typedef enum ser_state_t {IDLE, CT_LOAD, CT_SHIFT, TAG_WAIT, TAG_SHIFT, DONE}.
- The existing DATA_LENGTH and LENGTH constants are reused.
- One sub-module: cipher_word_shifter.
  - BLK_W-bit load/shift-left register plus word index counter.
  - Ports: load, data, shift, word, last_word.
  - Instantiated once and shared by the CT and TAG phases.

Test Plan:
1. Normal run:
   - Stimulus: data_len=2, word_ready_i=1, blocks 0x00112233_44556677_8899aabb_ccddeeff and 0xdeadbeef_..., then finish with tag 0xa5a5...a5.
   - Response: 8 CT words in MSW-first order (00112233 first), 4 tag words with word_is_tag_o=1, word_last_o only on the 12th word, done_o one cycle, busy_o falls.
2. Backpressure:
   - Stimulus: word_ready_i high 1 cycle in 3 during test 1.
   - Response: word_o stable while stalled, identical 12-word sequence, no duplicates or drops, blk_ready_o low during shifting.
3. Zero length:
   - Stimulus: data_len=0, start, finish 5 cycles later with tag 0x0123_4567_89ab_cdef_0123_4567_89ab_cdef.
   - Response: exactly 4 words 01234567, 89abcdef, 01234567, 89abcdef, blk_ready_o never 1.
4. Early finish:
   - Stimulus: finish_i with tag T while the first CT block is still shifting; tag_i then changed to 0.
   - Response: all CT words first, then T (not 0); a second finish pulse has no effect.
5. Reset mid-operation:
   - Stimulus: assert rst_i during CT_SHIFT word 2 (asynchronously, mid-cycle).
   - Response: all outputs 0 immediately, IDLE; a subsequent start with data_len=1 produces 4 CT + 4 tag words correctly.
6. Ignored events:
   - Stimulus: blk_valid_i and finish_i in IDLE; start_i while busy.
   - Response: blk_ready_o=0, no output words, block count unchanged.
